// File: rtl/multicycle_control.sv
// multicycle_control
//
// Finite-state controller for a shared multicycle MIPS datapath (register
// file, one ALU, unified instruction/data memory, IR and PC). One instruction
// is sequenced at a time from the opcode held in the IR, the ALU zero flag and
// a memory-ready handshake. All datapath enables and mux selects are Moore
// outputs of the current state, except ir_write/pc_en in FETCH (qualified by
// mem_ready) and pc_en in BRANCH (qualified by zero).
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   synchronous, active-high
//   opcode       in   6   IR[31:26], examined in DECODE and MEM_ADDR
//   zero         in   1   ALU zero flag
//   mem_ready    in   1   memory completes the current access this cycle
//   pc_en        out  1   PC load enable
//   pc_source    out  2   00 ALU result, 01 ALUOut, 10 jump target
//   i_or_d       out  1   memory address: 0 PC, 1 ALUOut
//   mem_read     out  1   memory read strobe
//   mem_write    out  1   memory write strobe
//   ir_write     out  1   IR load enable
//   reg_write    out  1   register file write enable
//   reg_dst      out  1   write register: 0 rt, 1 rd
//   mem_to_reg   out  1   write data: 0 ALUOut, 1 MDR
//   alu_src_a    out  1   0 PC, 1 rs_data
//   alu_src_b    out  2   00 rt_data, 01 const 4, 10 sext imm, 11 imm<<2
//   alu_op       out  2   00 add, 01 sub, 10 funct-decoded
//   illegal_op   out  1   unsupported opcode seen in DECODE
//   state        out  4   current state encoding (debug)
//   retired      out  16  retired-instruction count, wraps

module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic [1:0]  pc_source,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        illegal_op,
  output logic [3:0]  state,
  output logic [15:0] retired
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    ALU_WB    = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EX   = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] retired_q;
  logic        retire;

  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  pc_source_c;
  logic        i_or_d_c;
  logic        mem_read_c;
  logic        mem_write_c;
  logic        ir_write_c;
  logic        reg_write_c;
  logic        reg_dst_c;
  logic        mem_to_reg_c;
  logic        alu_src_a_c;
  logic [1:0]  alu_src_b_c;
  logic [1:0]  alu_op_c;
  logic        illegal_c;

  // State register and retired-instruction counter. Reset abandons any
  // instruction in flight without counting it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      retired_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        retired_q <= retired_q + 16'd1;
      end
    end
  end

  // Next-state and Moore output decode. 'retire' marks the final cycle of a
  // completed instruction, i.e. a transition back to FETCH from a terminal
  // state; the illegal-opcode path out of DECODE deliberately leaves it low.
  always_comb begin
    state_d       = FETCH;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source_c   = 2'b00;
    i_or_d_c      = 1'b0;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;
    ir_write_c    = 1'b0;
    reg_write_c   = 1'b0;
    reg_dst_c     = 1'b0;
    mem_to_reg_c  = 1'b0;
    alu_src_a_c   = 1'b0;
    alu_src_b_c   = 2'b00;
    alu_op_c      = 2'b00;
    illegal_c     = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        ir_write_c  = mem_ready;
        pc_write    = mem_ready;
        state_d     = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b_c = 2'b11;
        case (opcode)
          OP_RTYPE:      state_d = EXECUTE;
          OP_LW, OP_SW:  state_d = MEM_ADDR;
          OP_BEQ:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
          OP_ADDI:       state_d = ADDI_EX;
          default: begin
            illegal_c = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        // Only lw/sw reach here; a changed IR falls back to FETCH uncounted.
        if (opcode == OP_LW) begin
          state_d = MEM_READ;
        end else if (opcode == OP_SW) begin
          state_d = MEM_WRITE;
        end else begin
          state_d = FETCH;
        end
      end
      MEM_READ: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
        state_d    = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        retire       = 1'b1;
        state_d      = FETCH;
      end
      MEM_WRITE: begin
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
        retire      = mem_ready;
        state_d     = mem_ready ? FETCH : MEM_WRITE;
      end
      EXECUTE: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        state_d     = ALU_WB;
      end
      ALU_WB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        alu_src_a_c   = 1'b1;
        alu_op_c      = 2'b01;
        pc_write_cond = 1'b1;
        pc_source_c   = 2'b01;
        retire        = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write    = 1'b1;
        pc_source_c = 2'b10;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      ADDI_EX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write_c = 1'b1;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Every output is forced low while reset is held, so a reset arriving
  // mid-access drops the pending strobe in that very cycle.
  assign pc_en      = ~reset & (pc_write | (pc_write_cond & zero));
  assign pc_source  = reset ? 2'b00 : pc_source_c;
  assign i_or_d     = ~reset & i_or_d_c;
  assign mem_read   = ~reset & mem_read_c;
  assign mem_write  = ~reset & mem_write_c;
  assign ir_write   = ~reset & ir_write_c;
  assign reg_write  = ~reset & reg_write_c;
  assign reg_dst    = ~reset & reg_dst_c;
  assign mem_to_reg = ~reset & mem_to_reg_c;
  assign alu_src_a  = ~reset & alu_src_a_c;
  assign alu_src_b  = reset ? 2'b00 : alu_src_b_c;
  assign alu_op     = reset ? 2'b00 : alu_op_c;
  assign illegal_op = ~reset & illegal_c;
  assign state      = reset ? 4'd0 : state_q;
  assign retired    = reset ? 16'd0 : retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//
// Directed, table-driven bench for multicycle_control. Each table record is
// one clock cycle: inputs applied after the falling edge, outputs compared a
// little later while the clock is still low. A hand-written sequence covers
// the retired-counter wrap.

module tb_multicycle_control;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_en;
  logic [1:0]  pc_source;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        illegal_op;
  logic [3:0]  state;
  logic [15:0] retired;

  int tests_run;
  int tests_failed;

  // Control outputs packed as
  // {pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
  //  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op}
  logic [15:0] ctl;
  assign ctl = {pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                alu_op, illegal_op};

  localparam logic [15:0] C_ZERO     = 16'b0_00_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [15:0] C_FETCH    = 16'b1_00_0_1_0_1_0_0_0_0_01_00_0;
  localparam logic [15:0] C_FWAIT    = 16'b0_00_0_1_0_0_0_0_0_0_01_00_0;
  localparam logic [15:0] C_DEC      = 16'b0_00_0_0_0_0_0_0_0_0_11_00_0;
  localparam logic [15:0] C_DEC_ILL  = 16'b0_00_0_0_0_0_0_0_0_0_11_00_1;
  localparam logic [15:0] C_ADDR     = 16'b0_00_0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [15:0] C_MRD      = 16'b0_00_1_1_0_0_0_0_0_0_00_00_0;
  localparam logic [15:0] C_MWB      = 16'b0_00_0_0_0_0_1_0_1_0_00_00_0;
  localparam logic [15:0] C_MWR      = 16'b0_00_1_0_1_0_0_0_0_0_00_00_0;
  localparam logic [15:0] C_EXEC     = 16'b0_00_0_0_0_0_0_0_0_1_00_10_0;
  localparam logic [15:0] C_ALUWB    = 16'b0_00_0_0_0_0_1_1_0_0_00_00_0;
  localparam logic [15:0] C_BR1      = 16'b1_01_0_0_0_0_0_0_0_1_00_01_0;
  localparam logic [15:0] C_BR0      = 16'b0_01_0_0_0_0_0_0_0_1_00_01_0;
  localparam logic [15:0] C_JMP      = 16'b1_10_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [15:0] C_AWB      = 16'b0_00_0_0_0_0_1_0_0_0_00_00_0;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        z;
    logic        rdy;
    logic [3:0]  exp_state;
    logic [15:0] exp_ctl;
    logic [15:0] exp_retired;
  } vec_t;

  vec_t vecs[$];

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .pc_source  (pc_source),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .state      (state),
    .retired    (retired)
  );

  // 10-time-unit clock; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic rst, input logic [5:0] op,
                              input logic z, input logic rdy,
                              input logic [3:0] st, input logic [15:0] c,
                              input logic [15:0] ret);
    vec_t v;
    v.rst = rst; v.op = op; v.z = z; v.rdy = rdy;
    v.exp_state = st; v.exp_ctl = c; v.exp_retired = ret;
    vecs.push_back(v);
  endfunction

  // Drive one cycle's inputs.
  task automatic applyStimulus(input logic rst, input logic [5:0] op,
                               input logic z, input logic rdy);
    reset     = rst;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
  endtask

  // One comparison: count it and report a mismatch.
  task automatic checkOutput(input string name, input logic [15:0] got,
                             input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at time %0t",
               name, got, exp, $time);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    applyStimulus(1'b1, OP_R, 1'b0, 1'b1);

    // Reset held for two cycles
    add(1, OP_R,    0, 1, 4'd0, C_ZERO,  16'd0);
    add(1, OP_R,    0, 1, 4'd0, C_ZERO,  16'd0);
    // lw, mem_ready high: 0,1,2,3,4 then FETCH with retired=1
    add(0, OP_LW,   0, 1, 4'd0, C_FETCH, 16'd0);
    add(0, OP_LW,   1, 1, 4'd1, C_DEC,   16'd0);
    add(0, OP_LW,   0, 1, 4'd2, C_ADDR,  16'd0);
    add(0, OP_LW,   0, 1, 4'd3, C_MRD,   16'd0);
    add(0, OP_LW,   0, 1, 4'd4, C_MWB,   16'd0);
    // sw with three wait cycles in MEM_WRITE: 7 cycles total
    add(0, OP_SW,   0, 1, 4'd0, C_FETCH, 16'd1);
    add(0, OP_SW,   0, 1, 4'd1, C_DEC,   16'd1);
    add(0, OP_SW,   0, 1, 4'd2, C_ADDR,  16'd1);
    add(0, OP_SW,   0, 0, 4'd5, C_MWR,   16'd1);
    add(0, OP_SW,   0, 0, 4'd5, C_MWR,   16'd1);
    add(0, OP_SW,   0, 0, 4'd5, C_MWR,   16'd1);
    add(0, OP_SW,   0, 1, 4'd5, C_MWR,   16'd1);
    // R-type
    add(0, OP_R,    0, 1, 4'd0, C_FETCH, 16'd2);
    add(0, OP_R,    0, 1, 4'd1, C_DEC,   16'd2);
    add(0, OP_R,    1, 1, 4'd6, C_EXEC,  16'd2);
    add(0, OP_R,    0, 1, 4'd7, C_ALUWB, 16'd2);
    // beq taken
    add(0, OP_BEQ,  0, 1, 4'd0, C_FETCH, 16'd3);
    add(0, OP_BEQ,  0, 1, 4'd1, C_DEC,   16'd3);
    add(0, OP_BEQ,  1, 1, 4'd8, C_BR1,   16'd3);
    // beq not taken
    add(0, OP_BEQ,  0, 1, 4'd0, C_FETCH, 16'd4);
    add(0, OP_BEQ,  0, 1, 4'd1, C_DEC,   16'd4);
    add(0, OP_BEQ,  0, 1, 4'd8, C_BR0,   16'd4);
    // j
    add(0, OP_J,    0, 1, 4'd0, C_FETCH, 16'd5);
    add(0, OP_J,    0, 1, 4'd1, C_DEC,   16'd5);
    add(0, OP_J,    0, 1, 4'd9, C_JMP,   16'd5);
    // addi
    add(0, OP_ADDI, 0, 1, 4'd0, C_FETCH, 16'd6);
    add(0, OP_ADDI, 0, 1, 4'd1, C_DEC,   16'd6);
    add(0, OP_ADDI, 0, 1, 4'd10, C_ADDR, 16'd6);
    add(0, OP_ADDI, 0, 1, 4'd11, C_AWB,  16'd6);
    // illegal opcode: two cycles, no retire
    add(0, OP_BAD,  0, 1, 4'd0, C_FETCH, 16'd7);
    add(0, OP_BAD,  0, 1, 4'd1, C_DEC_ILL, 16'd7);
    // FETCH stalled twice; no ir_write / pc_en until ready
    add(0, OP_LW,   1, 0, 4'd0, C_FWAIT, 16'd7);
    add(0, OP_LW,   0, 0, 4'd0, C_FWAIT, 16'd7);
    add(0, OP_LW,   0, 1, 4'd0, C_FETCH, 16'd7);
    // lw abandoned by reset during MEM_READ
    add(0, OP_LW,   0, 1, 4'd1, C_DEC,   16'd7);
    add(0, OP_LW,   0, 1, 4'd2, C_ADDR,  16'd7);
    add(0, OP_LW,   0, 0, 4'd3, C_MRD,   16'd7);
    add(1, OP_LW,   0, 0, 4'd0, C_ZERO,  16'd0);
    add(0, OP_LW,   0, 1, 4'd0, C_FETCH, 16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].rdy);
      #2;
      checkOutput($sformatf("vec%0d state", i), {12'd0, state},
                  {12'd0, vecs[i].exp_state});
      checkOutput($sformatf("vec%0d ctl", i), ctl, vecs[i].exp_ctl);
      checkOutput($sformatf("vec%0d retired", i), retired,
                  vecs[i].exp_retired);
    end

    // Counter wrap: preload 0xFFFF, then one j must roll it to 0x0000.
    @(negedge clk);
    applyStimulus(1'b1, OP_J, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, OP_J, 1'b0, 1'b1);
    force dut.retired_q = 16'hFFFF;
    #2;
    checkOutput("wrap fetch state", {12'd0, state}, 16'd0);
    @(negedge clk);
    release dut.retired_q;
    #2;
    checkOutput("wrap decode state", {12'd0, state}, 16'd1);
    checkOutput("wrap preload", retired, 16'hFFFF);
    @(negedge clk);
    #2;
    checkOutput("wrap jump state", {12'd0, state}, 16'd9);
    checkOutput("wrap jump ctl", ctl, C_JMP);
    @(negedge clk);
    #2;
    checkOutput("wrap back to fetch", {12'd0, state}, 16'd0);
    checkOutput("wrap retired", retired, 16'h0000);
    // One more j counts from zero again
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2;
    checkOutput("post-wrap retired", retired, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Finite-state controller that sequences the shared multicycle MIPS datapath: register file, single ALU, unified instruction/data memory, IR, and PC. It reads the opcode latched in the IR plus the ALU zero flag and a memory-ready handshake. It drives every datapath enable and mux select, one instruction at a time. It also flags unsupported opcodes and counts retired instructions.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- opcode  input  6  instruction[31:26] from IR; sampled only in DECODE, MEM_ADDR.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_en  output  1  PC load enable = pc_write | (pc_write_cond & zero).
- pc_source  output  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
- i_or_d  output  1  memory address: 0 PC, 1 ALUOut.
- mem_read, mem_write  output  1 each  memory strobes.
- ir_write  output  1  IR load enable.
- reg_write  output  1  register file write enable.
- reg_dst  output  1  write register: 0 rt, 1 rd.
- mem_to_reg  output  1  write data: 0 ALUOut, 1 MDR.
- alu_src_a  output  1  0 PC, 1 rs_data.
- alu_src_b  output  2  00 rt_data, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- alu_op  output  2  00 add, 01 sub, 10 funct-decoded.
- illegal_op  output  1  unsupported opcode in DECODE.
- state  output  4  current state encoding, for debug.
- retired  output  16  retired-instruction count, wraps.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Moore outputs are decoded from state. Unlisted outputs are 0 in each state. pc_write and pc_write_cond are internal.
- States and encodings:
  - FETCH (0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write = pc_write = mem_ready. Stay while !mem_ready, else go to DECODE.
  - DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=00. Branch on opcode: R to EXECUTE, lw/sw to MEM_ADDR, beq to BRANCH, j to JUMP, addi to ADDI_EX. Any other opcode sets illegal_op=1 and goes to FETCH.
  - MEM_ADDR (2): alu_src_a=1, alu_src_b=10, alu_op=00. lw goes to MEM_READ, sw goes to MEM_WRITE.
  - MEM_READ (3): mem_read=1, i_or_d=1. Wait for mem_ready, then go to MEM_WB.
  - MEM_WB (4): reg_write=1, reg_dst=0, mem_to_reg=1. Then FETCH.
  - MEM_WRITE (5): mem_write=1, i_or_d=1. Wait for mem_ready, then go to FETCH.
  - EXECUTE (6): alu_src_a=1, alu_src_b=00, alu_op=10. Then ALU_WB.
  - ALU_WB (7): reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
  - BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Then FETCH.
  - JUMP (9): pc_write=1, pc_source=10. Then FETCH.
  - ADDI_EX (10): alu_src_a=1, alu_src_b=10, alu_op=00. Then ADDI_WB.
  - ADDI_WB (11): reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
  - Encodings 12–15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.
- retired increments by 1 on every transition into FETCH from states 4, 5, 7, 8, 9, 11. It wraps 0xFFFF to 0x0000. An illegal opcode does not increment it.

## Timing
- Reset:
  - While reset is high, every output is 0, including all strobes and enables.
  - At the edge with reset high, state becomes FETCH and retired becomes 0.
  - Reset mid-instruction abandons the instruction with no retire. A pending memory access is dropped.
- Latency with mem_ready held at 1:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each cycle of mem_ready=0 in FETCH, MEM_READ, or MEM_WRITE adds exactly one cycle.
- Strobes stay high and stable throughout a wait. ir_write and pc_en stay 0 until the mem_ready cycle.
- pc_en is combinational on zero in BRANCH only.

## Test plan
- Reset then lw, mem_ready=1: states 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in cycle 5. retired=1.
- sw with mem_ready low for 3 cycles in MEM_WRITE: mem_write=1 for 4 consecutive cycles, then FETCH. Total 7 cycles. retired increments once.
- beq with zero=1: pc_en=1 and pc_source=01 in BRANCH. Repeat with zero=0: pc_en=0. Both complete in 3 cycles.
- Opcode 111111: illegal_op=1 for the DECODE cycle only, returns to FETCH, retired unchanged.
- reset asserted during MEM_READ: outputs 0 that cycle, next state FETCH, retired=0.
- Preload retired=0xFFFF via 65535 j instructions (or force): the next j yields 0x0000.
